// File: rtl/rightshift_seq_pkg.sv
// Shared constants and encodings for the sequential right shifter.
package rightshift_seq_pkg;
  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic SHIFT_ARITH = 1'b1;
  localparam logic SHIFT_LOGIC = 1'b0;
endpackage

// File: rtl/rightshift_stage.sv
// One power-of-two right-shift stage: shifts by 2**k_i when enabled.
// The vacated upper bits take fill_i.
module rightshift_stage #(
  parameter int WIDTH = 32,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] w_i,
  input  logic [KW-1:0]    k_i,
  input  logic             en_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] w_o
);
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fill_mask;

  always_comb begin
    shifted   = w_i >> (1 << k_i);
    fill_mask = ~({WIDTH{1'b1}} >> (1 << k_i));
    w_o       = w_i;
    if (en_i) w_o = shifted | (fill_i ? fill_mask : '0);
  end
endmodule

// File: rtl/rightshift_seq.sv
// Multi-cycle right shifter (srl/sra): one power-of-two stage per clock,
// MSB stage first, fixed SHAMT_W-cycle latency with start/ready handshake.
module rightshift_seq
  import rightshift_seq_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ctrl_start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  logic               ctrl_arith,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_resultRDY,
  output logic               busy
);
  localparam int KW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   w_q, w_d;
  logic [SHAMT_W-1:0] a_q, a_d;
  logic               f_q, f_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   stage_w;

  // A single stage reused every cycle, stepped by the counter.
  rightshift_stage #(.WIDTH(WIDTH), .KW(KW)) u_stage (
    .w_i    (w_q),
    .k_i    (k_q),
    .en_i   (a_q[k_q]),
    .fill_i (f_q),
    .w_o    (stage_w)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    w_d        = w_q;
    a_d        = a_q;
    f_d        = f_q;
    data_out_d = data_out_q;
    rdy_d      = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          w_d     = data_in;
          a_d     = shift_amount;
          f_d     = (ctrl_arith == SHIFT_ARITH) & data_in[WIDTH-1];
          k_d     = KW'(SHAMT_W - 1);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        w_d = stage_w;
        if (k_q != '0) begin
          k_d = k_q - 1'b1;
        end else begin
          data_out_d = stage_w;
          rdy_d      = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      w_q        <= '0;
      a_q        <= '0;
      f_q        <= 1'b0;
      data_out_q <= '0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      w_q        <= w_d;
      a_q        <= a_d;
      f_q        <= f_d;
      data_out_q <= data_out_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_rightshift_seq.sv
// Bench for rightshift_seq: cycle model built from the handshake rules,
// checked every cycle, plus directed literal cases and a random phase.
module tb_rightshift_seq;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_start = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  shift_amount = '0;
  logic        ctrl_arith = 1'b0;
  logic [31:0] data_out;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  rightshift_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_start     (ctrl_start),
    .data_in        (data_in),
    .shift_amount   (shift_amount),
    .ctrl_arith     (ctrl_arith),
    .data_out       (data_out),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt, input logic ar);
    if (ar) return 32'($signed(d) >>> amt);
    return d >> amt;
  endfunction

  // Behavioural model: a busy countdown of 5 edges, result computed
  // directly with the language shift operators.
  logic [31:0] m_out, m_res;
  logic        m_rdy, m_busy;
  int          m_cnt;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_out = '0; m_res = '0; m_rdy = 1'b0; m_busy = 1'b0; m_cnt = 0;
    end else begin
      m_rdy = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_out  = m_res;
          m_rdy  = 1'b1;
        end
      end else if (ctrl_start) begin
        m_busy = 1'b1;
        m_cnt  = 5;
        m_res  = ref_shift(data_in, int'(shift_amount), ctrl_arith);
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clock) begin
    if (cmp_en && reset_n) begin
      check("cyc_data_out", data_out, m_out);
      check("cyc_rdy", {31'b0, data_resultRDY}, {31'b0, m_rdy});
      check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
    end
  end

  // Caller sits at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [31:0] d, input logic [4:0] amt, input logic ar);
    ctrl_start = 1'b1; data_in = d; shift_amount = amt; ctrl_arith = ar;
    @(negedge clock);
    ctrl_start = 1'b0;
  endtask

  // lat0 = edges already elapsed since the start edge; returns at the ready negedge.
  task automatic wait_rdy(input string name, input logic [31:0] exp, input int lat0);
    int lat = lat0;
    while (!data_resultRDY && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd5);
    check({name, "_data"}, data_out, exp);
    check({name, "_model"}, m_out, exp);
  endtask

  initial begin
    int pulses;
    repeat (2) @(negedge clock);
    check("reset_data_out", data_out, 32'h0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    cmp_en = 1'b1;

    issue(32'h8000_0000, 5'd4, 1'b0);
    check("srl4_busy", {31'b0, busy}, 32'h1);
    wait_rdy("srl4", 32'h0800_0000, 0);
    @(negedge clock);
    check("srl4_rdy_one_cycle", {31'b0, data_resultRDY}, 32'h0);

    issue(32'h8000_0000, 5'd4, 1'b1);
    wait_rdy("sra4", 32'hF800_0000, 0);
    issue(32'h8000_0001, 5'd31, 1'b1);
    wait_rdy("sra31", 32'hFFFF_FFFF, 0);
    issue(32'h8000_0001, 5'd31, 1'b0);
    wait_rdy("srl31", 32'h0000_0001, 0);
    issue(32'h1234_5678, 5'd0, 1'b0);
    wait_rdy("zero", 32'h1234_5678, 0);

    // Start while busy is ignored.
    @(negedge clock);
    issue(32'h0000_F000, 5'd8, 1'b0);
    @(negedge clock);
    issue(32'hFFFF_FFFF, 5'd1, 1'b1);
    wait_rdy("busy_ign", 32'h0000_00F0, 2);
    pulses = 0;
    repeat (10) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    check("busy_ign_no_2nd", 32'(pulses), 32'd0);

    // Back-to-back: start accepted in the ready cycle.
    issue(32'h0000_00FF, 5'd4, 1'b0);
    wait_rdy("b2b_first", 32'h0000_000F, 0);
    issue(32'h4000_0000, 5'd30, 1'b0);
    wait_rdy("b2b_second", 32'h0000_0001, 0);

    // Reset mid-operation.
    @(negedge clock);
    issue(32'hDEAD_BEEF, 5'd3, 1'b1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_data_out", data_out, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_rdy", {31'b0, data_resultRDY}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    check("mid_rst_no_pulse", 32'(pulses), 32'd0);
    issue(32'hFFFF_0000, 5'd16, 1'b1);
    wait_rdy("post_rst", 32'hFFFF_FFFF, 0);

    // Random phase: the per-cycle compare against the model does the work.
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      ctrl_start   = ($urandom_range(0, 2) == 0);
      data_in      = $urandom;
      shift_amount = 5'($urandom_range(0, 31));
      ctrl_arith   = 1'($urandom);
    end
    @(negedge clock);
    ctrl_start = 1'b0;
    repeat (8) @(negedge clock);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
